// File: rtl/softmax_exp_sched_if.sv
// Element input stream and tagged result output stream of softmax_exp_sched.
// The slave view belongs to the scheduler; the master view belongs to its neighbours.
interface softmax_exp_sched_if #(
    parameter int IDX_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;

    logic             out_valid;
    logic             out_ready;
    logic [28:0]      out_m;
    logic [4:0]       out_j;
    logic [17:0]      out_r;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_m, out_j, out_r, out_idx, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_m, out_j, out_r, out_idx, out_last
    );
endinterface

// File: rtl/softmax_exp_sched.sv
// Issues one softmax vector into the fixed-latency exp range-reduction datapath and
// collects tagged m/j/r results in a credit-protected FIFO.
module softmax_exp_sched #(
    parameter int LAT        = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int IDX_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [IDX_W-1:0]   vec_len,
    output logic               busy,
    output logic               done,
    softmax_exp_sched_if.slave bus,
    output logic [31:0]        jmr_x,
    input  logic [28:0]        jmr_m,
    input  logic [4:0]         jmr_j,
    input  logic [17:0]        jmr_r
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W:0]   CREDITS = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
        logic             last;
    } tag_t;

    typedef struct packed {
        logic [28:0]      m;
        logic [4:0]       j;
        logic [17:0]      r;
        logic [IDX_W-1:0] idx;
        logic             last;
    } result_t;

    state_t           state;
    logic [IDX_W-1:0] len;
    logic [IDX_W-1:0] issue_cnt;

    tag_t             tag_pipe [LAT];

    result_t          fifo_mem [FIFO_DEPTH];
    result_t          head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] occupancy;
    logic [CNT_W:0]   credit_used;

    logic             handshake;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_MAX) ? '0 : p + PTR_ONE;
    endfunction

    // Credits count results already promised to the FIFO, so a push can never find it full.
    assign credit_used  = {1'b0, inflight} + {1'b0, occupancy};
    assign bus.in_ready = (state == S_RUN) && (issue_cnt < len) && (credit_used < CREDITS);

    assign handshake = bus.in_valid && bus.in_ready;
    assign push      = tag_pipe[LAT-1].valid;
    assign pop       = bus.out_valid && bus.out_ready;

    assign busy = (state != S_IDLE);

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            len       <= '0;
            issue_cnt <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (vec_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            len       <= vec_len;
                            issue_cnt <= '0;
                            state     <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (handshake) begin
                        issue_cnt <= issue_cnt + IDX_ONE;
                        if (issue_cnt + IDX_ONE == len) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pop && bus.out_last && (inflight == '0) && (occupancy == CNT_ONE)) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Operand register; it simply holds between handshakes since stale results carry no valid tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            jmr_x <= '0;
        end else if (handshake) begin
            jmr_x <= bus.in_data;
        end
    end

    // Tag stage LAT-1 lines up with the datapath result present on jmr_* this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0].valid <= handshake;
            tag_pipe[0].idx   <= issue_cnt;
            tag_pipe[0].last  <= (issue_cnt == len - IDX_ONE);
            for (int i = 1; i < LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight  <= '0;
            occupancy <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            case ({handshake, push})
                2'b10:   inflight <= inflight + CNT_ONE;
                2'b01:   inflight <= inflight - CNT_ONE;
                default: inflight <= inflight;
            endcase
            case ({push, pop})
                2'b10:   occupancy <= occupancy + CNT_ONE;
                2'b01:   occupancy <= occupancy - CNT_ONE;
                default: occupancy <= occupancy;
            endcase
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
        end
    end

    // NOTE: the storage array is deliberately left out of reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr].m    <= jmr_m;
            fifo_mem[wr_ptr].j    <= jmr_j;
            fifo_mem[wr_ptr].r    <= jmr_r;
            fifo_mem[wr_ptr].idx  <= tag_pipe[LAT-1].idx;
            fifo_mem[wr_ptr].last <= tag_pipe[LAT-1].last;
        end
    end

    assign head          = fifo_mem[rd_ptr];
    assign bus.out_valid = (occupancy != '0);
    assign bus.out_m     = head.m;
    assign bus.out_j     = head.j;
    assign bus.out_r     = head.r;
    assign bus.out_idx   = head.idx;
    assign bus.out_last  = head.last;

endmodule

// File: tb/tb_softmax_exp_sched.sv
// Directed bench for softmax_exp_sched: datapath stub, feed queue and result scoreboard.
// Inputs change 1 ns after the rising edge; outputs are observed on the falling edge.
module tb_softmax_exp_sched;

    localparam int LAT        = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int IDX_W      = 8;

    typedef struct {
        logic [28:0]      m;
        logic [4:0]       j;
        logic [17:0]      r;
        logic [IDX_W-1:0] idx;
        logic             last;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [IDX_W-1:0] vec_len;
    logic             busy;
    logic             done;
    logic [31:0]      jmr_x;
    logic [28:0]      jmr_m;
    logic [4:0]       jmr_j;
    logic [17:0]      jmr_r;

    softmax_exp_sched_if #(.IDX_W(IDX_W)) bus ();

    softmax_exp_sched #(
        .LAT       (LAT),
        .FIFO_DEPTH(FIFO_DEPTH),
        .IDX_W     (IDX_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .vec_len(vec_len),
        .busy   (busy),
        .done   (done),
        .bus    (bus),
        .jmr_x  (jmr_x),
        .jmr_m  (jmr_m),
        .jmr_j  (jmr_j),
        .jmr_r  (jmr_r)
    );

    always #5 clk = ~clk;

    // Datapath stub: LAT-1 register stages after jmr_x, then fixed bit slices of x.
    logic [31:0] dp_pipe [LAT-1];
    always @(posedge clk) begin
        dp_pipe[0] <= jmr_x;
        for (int k = 1; k < LAT - 1; k++) begin
            dp_pipe[k] <= dp_pipe[k-1];
        end
    end
    assign jmr_m = dp_pipe[LAT-2][28:0];
    assign jmr_j = dp_pipe[LAT-2][4:0];
    assign jmr_r = dp_pipe[LAT-2][17:0];

    int          total = 0;
    int          bad = 0;
    exp_t        sbq[$];
    logic [31:0] feed_q[$];
    int          cycle = 0;
    int          cur_len = 0;
    int          vec_idx = 0;
    int          hs_vec = 0;
    int          pop_vec = 0;
    int          done_cnt = 0;
    int          done_cycle = 0;
    int          last_pop_cycle = 0;
    int          first_hs = -1;
    int          first_ov = -1;
    bit          consec_chk = 1'b0;
    bit          toggle_mode = 1'b0;
    bit          toggle_ph = 1'b0;
    bit          rand_ready = 1'b0;
    bit          prev_stall = 1'b0;
    logic [IDX_W-1:0] prev_idx;
    logic [28:0]      prev_m;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic begin_vector(input int n);
        cur_len = n;
        vec_idx = 0;
        hs_vec  = 0;
        pop_vec = 0;
    endtask

    task automatic sample();
        exp_t e;
        @(negedge clk);
        cycle++;
        if (prev_stall) begin
            check("hold_valid", bus.out_valid, 1);
            check("hold_idx", bus.out_idx, prev_idx);
            check("hold_m", bus.out_m, prev_m);
        end
        if (bus.in_valid && bus.in_ready) begin
            e.m    = bus.in_data[28:0];
            e.j    = bus.in_data[4:0];
            e.r    = bus.in_data[17:0];
            e.idx  = vec_idx[IDX_W-1:0];
            e.last = (vec_idx == cur_len - 1);
            sbq.push_back(e);
            vec_idx++;
            hs_vec++;
            void'(feed_q.pop_front());
            if (first_hs < 0) first_hs = cycle;
        end
        if (bus.out_valid && first_ov < 0) first_ov = cycle;
        if (bus.out_valid && bus.out_ready) begin
            if (consec_chk && pop_vec > 0) check("pop_gap", cycle - last_pop_cycle, 1);
            check("sb_has_entry", sbq.size() > 0, 1);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("out_idx", bus.out_idx, e.idx);
                check("out_last", bus.out_last, e.last);
                check("out_m", bus.out_m, e.m);
                check("out_j", bus.out_j, e.j);
                check("out_r", bus.out_r, e.r);
            end
            pop_vec++;
            last_pop_cycle = cycle;
        end
        if (done) begin
            done_cnt++;
            done_cycle = cycle;
        end
        prev_stall = bus.out_valid && !bus.out_ready && !rst;
        prev_idx   = bus.out_idx;
        prev_m     = bus.out_m;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        toggle_ph    = !toggle_ph;
        bus.in_valid = (feed_q.size() > 0) && (!toggle_mode || toggle_ph);
        bus.in_data  = (feed_q.size() > 0) ? feed_q[0] : 32'h0;
        if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic step();
        advance();
        sample();
    endtask

    task automatic run_until_done(input string tag, input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            step();
            n++;
        end
        check(tag, done_cnt != d0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int n;
        rst           = 1'b1;
        start         = 1'b0;
        vec_len       = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sample();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_jmr_x", jmr_x, 0);
        advance();
        rst = 1'b0;
        sample();

        // Basic vector of five, full throughput.
        for (int i = 0; i < 5; i++) feed_q.push_back(32'h3F80_0000 + i);
        bus.out_ready = 1'b1;
        consec_chk    = 1'b1;
        first_hs      = -1;
        first_ov      = -1;
        advance();
        start = 1'b1; vec_len = 8'd5; begin_vector(5);
        sample();
        advance();
        start = 1'b0;
        sample();
        check("t1_busy", busy, 1);
        run_until_done("t1_done", 60);
        check("t1_latency", first_ov - first_hs, 5);
        check("t1_done_after_pop", done_cycle - last_pop_cycle, 1);
        check("t1_pops", pop_vec, 5);
        check("t1_sb_empty", sbq.size(), 0);
        consec_chk = 1'b0;

        // Twelve elements against a blocked output: credits stop issue at FIFO_DEPTH.
        for (int i = 0; i < 12; i++) feed_q.push_back(32'hA500_0000 + i * 32'h0001_0203);
        bus.out_ready = 1'b0;
        advance();
        start = 1'b1; vec_len = 8'd12; begin_vector(12);
        sample();
        advance();
        start = 1'b0;
        sample();
        repeat (30) step();
        check("t2_handshakes", hs_vec, 8);
        check("t2_in_ready", bus.in_ready, 0);
        check("t2_out_valid", bus.out_valid, 1);
        check("t2_head_idx", bus.out_idx, 0);
        check("t2_busy", busy, 1);
        advance();
        bus.out_ready = 1'b1;
        sample();
        run_until_done("t2_done", 200);
        check("t2_pops", pop_vec, 12);
        check("t2_sb_empty", sbq.size(), 0);

        // Gappy input and random backpressure.
        for (int i = 0; i < 4; i++) feed_q.push_back($urandom());
        toggle_mode = 1'b1;
        rand_ready  = 1'b1;
        d0 = done_cnt;
        advance();
        start = 1'b1; vec_len = 8'd4; begin_vector(4);
        sample();
        advance();
        start = 1'b0;
        sample();
        run_until_done("t3_done", 200);
        toggle_mode = 1'b0;
        rand_ready  = 1'b0;
        repeat (10) step();
        check("t3_done_once", done_cnt - d0, 1);
        check("t3_handshakes", hs_vec, 4);
        check("t3_pops", pop_vec, 4);
        check("t3_sb_empty", sbq.size(), 0);

        // Zero-length vector completes immediately without leaving IDLE.
        advance();
        start = 1'b1; vec_len = 8'd0;
        sample();
        check("t4_busy_a", busy, 0);
        advance();
        start = 1'b0;
        sample();
        check("t4_done", done, 1);
        check("t4_busy_b", busy, 0);
        check("t4_in_ready", bus.in_ready, 0);
        step();
        check("t4_done_clear", done, 0);
        check("t4_busy_c", busy, 0);

        // Reset after six issues and two pops of a ten-element vector.
        for (int i = 0; i < 6; i++) feed_q.push_back(32'h4000_0000 + i * 32'h111);
        bus.out_ready = 1'b0;
        advance();
        start = 1'b1; vec_len = 8'd10; begin_vector(10);
        sample();
        advance();
        start = 1'b0;
        sample();
        n = 0;
        while (hs_vec < 6 && n < 50) begin
            step();
            n++;
        end
        n = 0;
        while (pop_vec < 2 && n < 50) begin
            advance();
            bus.out_ready = 1'b1;
            sample();
            n++;
        end
        check("t5_issued", hs_vec, 6);
        check("t5_popped", pop_vec, 2);
        d0 = done_cnt;
        advance();
        bus.out_ready = 1'b0;
        rst = 1'b1;
        sample();
        advance();
        sample();
        check("t5_out_valid", bus.out_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_in_ready", bus.in_ready, 0);
        check("t5_done", done, 0);
        sbq.delete();
        feed_q.delete();
        advance();
        rst = 1'b0;
        sample();
        repeat (5) step();
        check("t5_no_done", done_cnt - d0, 0);
        check("t5_idle_empty", bus.out_valid, 0);
        for (int i = 0; i < 3; i++) feed_q.push_back(32'h1234_5678 + i);
        advance();
        bus.out_ready = 1'b1;
        start = 1'b1; vec_len = 8'd3; begin_vector(3);
        sample();
        advance();
        start = 1'b0;
        sample();
        run_until_done("t5b_done", 60);
        repeat (5) step();
        check("t5b_pops", pop_vec, 3);
        check("t5b_sb_empty", sbq.size(), 0);
        check("t5b_out_valid", bus.out_valid, 0);

        // A second start while running is ignored.
        for (int i = 0; i < 3; i++) feed_q.push_back(32'h7F00_0000 + i * 32'h0040_0001);
        d0 = done_cnt;
        advance();
        start = 1'b1; vec_len = 8'd3; begin_vector(3);
        sample();
        advance();
        start = 1'b0;
        sample();
        advance();
        start = 1'b1; vec_len = 8'd7;
        sample();
        advance();
        start = 1'b0;
        sample();
        run_until_done("t6_done", 60);
        repeat (10) step();
        check("t6_done_once", done_cnt - d0, 1);
        check("t6_handshakes", hs_vec, 3);
        check("t6_pops", pop_vec, 3);
        check("t6_busy", busy, 0);
        check("t6_sb_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
